// File: rtl/a2d_spi_resp_pkg.sv
// Shared types and defaults for the SPI ADC responder.
// Combinational only; no flow control.
package a2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int FRAME_BITS_DEF = 16;
    localparam int CHAN_LSB_DEF   = 11;
    localparam int CMD_W          = 16;
    localparam int RES_W          = 12;

    // Upper bits of the returned word above the 12-bit conversion result.
    localparam logic [3:0] RESULT_PAD = 4'h0;

endpackage

// File: rtl/a2d_spi_resp_if.sv
// SPI pins plus conversion-data handshake for the ADC responder.
// master = SPI initiator / ADC side, slave = the responder.
interface a2d_spi_resp_if;
    import a2d_pkg::*;

    logic             SS_n;
    logic             SCLK;
    logic             MOSI;
    logic             MISO;
    logic [RES_W-1:0] conv_data;
    logic             conv_req;
    logic [2:0]       chan;
    logic [CMD_W-1:0] cmd;
    logic             rdy;
    logic             err;

    modport slave (
        input  SS_n, SCLK, MOSI, conv_data,
        output MISO, conv_req, chan, cmd, rdy, err
    );

    modport master (
        output SS_n, SCLK, MOSI, conv_data,
        input  MISO, conv_req, chan, cmd, rdy, err
    );

endinterface

// File: rtl/a2d_spi_resp_sync_edge.sv
// Two-flop synchronizer plus an edge-detect flop; level and edges valid 2 clk after input.
// No backpressure: pulses are one clk wide and are simply dropped if unused.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI slave returning the previously requested 12-bit conversion; MISO lags raw SCLK fall by 3 clk.
// No backpressure: conv_data must be valid the clk conv_req is high.
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int CHAN_LSB   = CHAN_LSB_DEF
) (
    input  logic          clk,
    input  logic          rst,
    a2d_spi_resp_if.slave bus
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

    logic ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_lvl;
    logic ss_lvl_unused, sclk_lvl_unused;
    logic [1:0] mosi_edge_unused;

    sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(bus.SS_n),
        .q(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );
    sync_edge #(.RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst(rst), .d(bus.SCLK),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(bus.MOSI),
        .q(mosi_lvl), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
    );

    state_t           state;
    logic [CMD_W-1:0] tx_sr, rx_sr, cmd_q;
    logic [CW-1:0]    bit_cnt;
    logic [2:0]       chan_q;
    logic [RES_W-1:0] result;
    logic             rdy_q, err_q, conv_req_q, start_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            cmd_q      <= '0;
            chan_q     <= '0;
            result     <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            conv_req_q <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            conv_req_q <= rdy_q;
            if (conv_req_q)
                result <= bus.conv_data;

            case (state)
                IDLE: begin
                    // start_pend covers a slave-select fall that landed during DONE
                    if (ss_fall || start_pend) begin
                        state      <= SHIFT;
                        tx_sr      <= {RESULT_PAD, result};
                        bit_cnt    <= '0;
                        start_pend <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state <= DONE;
                    end else begin
                        if (sclk_rise && bit_cnt != FULL) begin
                            rx_sr   <= {rx_sr[CMD_W-2:0], mosi_lvl};
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                        if (sclk_fall && bit_cnt != '0)
                            tx_sr <= {tx_sr[CMD_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    start_pend <= ss_fall;
                    if (bit_cnt == FULL) begin
                        rdy_q  <= 1'b1;
                        cmd_q  <= rx_sr;
                        chan_q <= rx_sr[CHAN_LSB+2:CHAN_LSB];
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MISO     = (state == SHIFT) & tx_sr[CMD_W-1];
    assign bus.conv_req = conv_req_q;
    assign bus.chan     = chan_q;
    assign bus.cmd      = cmd_q;
    assign bus.rdy      = rdy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Scoreboard bench for a2d_spi_resp: directed SPI frames, expectations queued at issue,
// monitor pops on every rdy/err pulse and checks conv_req timing.
module tb_a2d_spi_resp;
    import a2d_pkg::*;

    localparam int H = 100;  // SCLK half-period: 10 clk

    typedef struct packed {
        logic [1:0]  kind;   // {err, rdy}
        logic [15:0] cmd;
        logic [2:0]  chan;
        logic [15:0] miso;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    a2d_spi_resp_if bus();

    a2d_spi_resp dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ADC model: fixed value per channel
    logic [11:0] chan_val [0:7] = '{12'h0C0, 12'h111, 12'h222, 12'h123,
                                    12'h444, 12'hABC, 12'h666, 12'h777};
    assign bus.conv_data = chan_val[bus.chan];

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  exp_q[$];
    logic [15:0] miso_word = '0;
    logic  prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rdy(input logic [15:0] c, input logic [2:0] ch, input logic [15:0] m);
        exp_t e;
        e.kind = 2'b01; e.cmd = c; e.chan = ch; e.miso = m;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [15:0] c, input logic [2:0] ch);
        exp_t e;
        e.kind = 2'b10; e.cmd = c; e.chan = ch; e.miso = '0;
        exp_q.push_back(e);
    endtask

    // Mode-3 initiator: drive MOSI on SCLK fall, slave output captured on rise.
    task automatic spi_frame(input logic [15:0] word, input int nbits, input bit end_ss, input int gap);
        bus.SS_n = 1'b0;
        #H;
        for (int i = 0; i < nbits; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = word[15-i];
            #H;
            bus.SCLK = 1'b1;
            #H;
        end
        if (end_ss) begin
            bus.SS_n = 1'b1;
            #(gap * H);
        end
    endtask

    always @(negedge bus.SS_n) miso_word = '0;
    always @(posedge bus.SCLK) if (!bus.SS_n) miso_word = {miso_word[14:0], bus.MISO};

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.conv_req || prev_rdy)
                chk("conv_req_after_rdy", 32'(bus.conv_req), 32'(prev_rdy));
            prev_rdy = bus.rdy;
            if (bus.rdy || bus.err) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: rdy=%0b err=%0b, expected none at %0t",
                             bus.rdy, bus.err, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", 32'({bus.err, bus.rdy}), 32'(e.kind));
                    chk("cmd", 32'(bus.cmd), 32'(e.cmd));
                    chk("chan", 32'(bus.chan), 32'(e.chan));
                    if (e.kind == 2'b01)
                        chk("miso_word", 32'(miso_word), 32'(e.miso));
                end
            end
        end
    end

    initial begin : stim
        rst      = 1'b1;
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        bus.MOSI = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_MISO", 32'(bus.MISO), 32'd0);
        chk("rst_chan", 32'(bus.chan), 32'd0);
        chk("rst_cmd", 32'(bus.cmd), 32'd0);
        chk("rst_rdy", 32'(bus.rdy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_conv_req", 32'(bus.conv_req), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // chan 5, result still 0 from reset
        push_rdy(16'h2800, 3'd5, 16'h0000);
        spi_frame(16'h2800, 16, 1'b1, 4);
        // chan 3, returns chan 5 value
        push_rdy(16'h1800, 3'd3, 16'h0ABC);
        spi_frame(16'h1800, 16, 1'b1, 4);
        // back to chan 5, returns chan 3 value
        push_rdy(16'h2800, 3'd5, 16'h0123);
        spi_frame(16'h2800, 16, 1'b1, 4);
        // abort after 8 bits: err, cmd/chan held
        push_err(16'h2800, 3'd5);
        spi_frame(16'h1800, 8, 1'b1, 4);
        // full frame still returns the pre-abort result
        push_rdy(16'h2800, 3'd5, 16'h0ABC);
        spi_frame(16'h2800, 16, 1'b1, 4);

        // reset 10 bits into a frame: no event, everything cleared
        spi_frame(16'h1800, 10, 1'b0, 0);
        rst      = 1'b1;
        bus.SS_n = 1'b1;
        bus.SCLK = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_MISO", 32'(bus.MISO), 32'd0);
        chk("midrst_chan", 32'(bus.chan), 32'd0);
        chk("midrst_cmd", 32'(bus.cmd), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        push_rdy(16'h3800, 3'd7, 16'h0000);
        spi_frame(16'h3800, 16, 1'b1, 4);

        // back-to-back with SS_n high for two half-periods
        push_rdy(16'h5A00, 3'd3, 16'h0777);
        spi_frame(16'h5A00, 16, 1'b1, 2);
        push_rdy(16'hC3A5, 3'd0, 16'h0123);
        spi_frame(16'hC3A5, 16, 1'b1, 4);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
